// File: rtl/add_seq_pkg.sv
// add_seq_pkg: shared widths, slice-count derivation and FSM encoding for add_seq32
package add_seq_pkg;
   localparam int WIDTH_DEF = 32;
   localparam int SLICE_DEF = 8;
   function automatic int nslice(input int w, input int sl);
      return w / sl;
   endfunction
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/add_seq32_slice_add8.sv
// slice_add8: combinational W-bit add with carry-in and carry-out
module slice_add8 #(
   parameter int W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
endmodule

// File: rtl/add_seq32.sv
// add_seq32: sequential adder processing SLICE bits per cycle, IDLE -> RUN -> DONE
module add_seq32
   import add_seq_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int SLICE = SLICE_DEF
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int NSLICE = nslice(WIDTH, SLICE);
   localparam int CW = NSLICE > 1 ? $clog2(NSLICE) : 1;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d, s_q, s_d;
   logic c_q, c_d, cout_q, cout_d, ovf_q, ovf_d;
   logic [SLICE-1:0] sl_a, sl_b, sl_s;
   logic sl_c, last;
   assign last = cnt_q == CW'(NSLICE - 1);
   assign sl_a = a_q[cnt_q*SLICE +: SLICE];
   assign sl_b = b_q[cnt_q*SLICE +: SLICE];
   slice_add8 #(.W(SLICE)) u_slice (
      .a   (sl_a),
      .b   (sl_b),
      .cin (c_q),
      .s   (sl_s),
      .cout(sl_c)
   );
   // all state: FSM, counter, captured operands, accumulator and result registers
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 1'b0;
         acc_q   <= '0;
         s_q     <= '0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         acc_q   <= acc_d;
         s_q     <= s_d;
         cout_q  <= cout_d;
         ovf_q   <= ovf_d;
      end
   end
   // next state: start only matters in IDLE, DONE always lasts one cycle
   always_comb begin
      state_d = state_q == IDLE ? (start ? RUN : IDLE) :
                state_q == RUN  ? (last ? DONE : RUN) : IDLE;
   end
   // datapath: capture on accepted start, one slice per RUN cycle, results loaded entering DONE
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      c_d    = c_q;
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      s_d    = s_q;
      cout_d = cout_q;
      ovf_d  = ovf_q;
      if (state_q == IDLE && start) begin
         a_d   = a;
         b_d   = b;
         c_d   = cin;
         cnt_d = '0;
      end
      if (state_q == RUN) begin
         acc_d[cnt_q*SLICE +: SLICE] = sl_s;
         c_d   = sl_c;
         cnt_d = last ? '0 : cnt_q + CW'(1);
         if (last) begin
            s_d    = acc_d;
            cout_d = sl_c;
            ovf_d  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (acc_d[WIDTH-1] != a_q[WIDTH-1]);
         end
      end
   end
   // outputs: status decoded from state, results straight from registers
   always_comb begin
      busy = state_q == RUN;
      done = state_q == DONE;
      s    = s_q;
      cout = cout_q;
      ovf  = ovf_q;
   end
endmodule

// File: tb/tb_add_seq32.sv
// tb_add_seq32: directed and random self-checking bench for add_seq32
module tb_add_seq32;
   logic clock = 1'b0, reset_n = 1'b0, start = 1'b0, cin = 1'b0;
   logic [31:0] a = '0, b = '0;
   logic busy, done, cout, ovf;
   logic [31:0] s;
   int n_chk = 0, n_err = 0;
   add_seq32 dut (
      .clock  (clock),
      .reset_n(reset_n),
      .start  (start),
      .a      (a),
      .b      (b),
      .cin    (cin),
      .busy   (busy),
      .done   (done),
      .s      (s),
      .cout   (cout),
      .ovf    (ovf)
   );
   always #5 clock = ~clock;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic run_op(input logic [31:0] va, input logic [31:0] vb, input logic vc,
                         input logic scram, input string tag);
      logic [32:0] full;
      logic eo;
      logic [31:0] s_prev;
      int lat, bad;
      full = {1'b0, va} + {1'b0, vb} + {32'd0, vc};
      eo = (va[31] == vb[31]) && (full[31] != va[31]);
      @(negedge clock);
      a = va; b = vb; cin = vc; start = 1'b1;
      s_prev = s;
      @(posedge clock); #1;
      start = 1'b0;
      check({tag, "_busy"}, busy, 1);
      lat = 0; bad = 0;
      for (int i = 1; i <= 12 && lat == 0; i++) begin
         if (scram) begin
            a = $urandom; b = $urandom; cin = 1'($urandom); start = 1'($urandom);
         end
         @(posedge clock); #1;
         if (busy && done) bad++;
         if (done) lat = i;
         else if (s !== s_prev) bad++;
      end
      start = 1'b0;
      check({tag, "_lat"}, lat, 4);
      check({tag, "_hold"}, bad, 0);
      check({tag, "_res"}, {cout, ovf, s}, {full[32], eo, full[31:0]});
      @(posedge clock); #1;
      check({tag, "_pulse"}, done, 0);
   endtask
   initial begin
      int ev[8];
      int n, nd;
      #2;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_res", {cout, ovf, s}, 0);
      @(negedge clock); reset_n = 1'b1;
      run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, "v1");
      run_op(32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, "v2");
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, "v3");
      run_op(32'h80000000, 32'h80000000, 1'b0, 1'b0, "v4");
      run_op(32'h12345678, 32'h87654321, 1'b0, 1'b0, "v5");
      check("v5_s", s, 32'h99999999);
      // start held high: acceptance every 6 edges
      @(negedge clock);
      a = 32'd1; b = 32'd2; cin = 1'b0; start = 1'b1;
      n = 0;
      for (int e = 0; e < 20; e++) begin
         @(posedge clock); #1;
         if (done && n < 8) begin ev[n] = e; n++; end
      end
      start = 1'b0;
      check("b2b_n", n, 3);
      if (n >= 3) begin
         check("b2b_gap1", ev[1] - ev[0], 6);
         check("b2b_gap2", ev[2] - ev[1], 6);
      end
      check("b2b_s", s, 32'd3);
      for (int i = 0; i < 10 && busy; i++) begin @(posedge clock); #1; end
      @(posedge clock); #1;
      @(posedge clock); #1;
      // start toggling through RUN/DONE yields exactly one result
      @(negedge clock);
      a = 32'd5; b = 32'd6; start = 1'b1;
      nd = 0;
      for (int e = 0; e < 5; e++) begin @(posedge clock); #1; if (done) nd++; end
      start = 1'b0;
      for (int e = 0; e < 8; e++) begin @(posedge clock); #1; if (done) nd++; end
      check("ign_ndone", nd, 1);
      check("ign_s", s, 32'd11);
      // reset during RUN with counter at 2
      @(negedge clock);
      a = 32'h11111111; b = 32'h22222222; start = 1'b1;
      @(posedge clock); #1; start = 1'b0;
      @(posedge clock); @(posedge clock); #2;
      reset_n = 1'b0; #1;
      check("mid_busy", busy, 0);
      check("mid_done", done, 0);
      check("mid_res", {cout, ovf, s}, 0);
      @(negedge clock); reset_n = 1'b1;
      nd = 0;
      for (int e = 0; e < 8; e++) begin @(posedge clock); #1; if (done) nd++; end
      check("mid_nodone", nd, 0);
      run_op(32'd3, 32'd4, 1'b0, 1'b0, "post");
      check("post_s", s, 32'd7);
      for (int i = 0; i < 1000; i++) run_op($urandom, $urandom, 1'($urandom), 1'b1, "rnd");
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
